// File: rtl/multi_correlator.sv
// Multi-channel rectangular-window correlator: per-window counts normalised and serialised as a byte packet.
// Packet byte 0 one cycle after the window-end strobe; stalled bytes hold; windows ending mid-packet are dropped and counted.
module multi_correlator #(
   parameter int N_CH                  = 4,
   parameter int MAX_WINDOW_LENGTH_EXP = 16,
   parameter int WLE_W                 = $clog2(MAX_WINDOW_LENGTH_EXP + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_cg,
   input  logic             i_strobe,
   input  logic [N_CH-1:0]  i_x,
   input  logic             i_y,
   input  logic [WLE_W-1:0] i_windowLengthExp,
   input  logic             i_clear,
   output logic [7:0]       o_bp_data,
   output logic             o_bp_valid,
   input  logic             i_bp_ready
);
   localparam int MW = MAX_WINDOW_LENGTH_EXP;
   localparam int CW = MW + 1;
   localparam int NB = 3 + 3 * N_CH;
   localparam int IW = $clog2(NB);

   typedef enum logic {IDLE, SEND} state_t;
   state_t state_q, stateNext;

   logic [WLE_W-1:0] wle_q, wleClamped;
   logic [MW-1:0]    t_q;
   logic [CW-1:0]    winSize, lastT;
   logic [CW-1:0]    cntY, cntYInc;
   logic [CW-1:0]    cntX [N_CH];
   logic [CW-1:0]    cntI [N_CH];
   logic [CW-1:0]    cntS [N_CH];
   logic [CW-1:0]    cntXInc [N_CH];
   logic [CW-1:0]    cntIInc [N_CH];
   logic [CW-1:0]    cntSInc [N_CH];
   logic [7:0]       winNum, dropCnt;
   logic [7:0]       shadow [NB];
   logic [7:0]       snap [NB];
   logic [IW-1:0]    idx_q, idxNext;
   logic             windowEnd, snapEvent, loadShadow;

   // Scale a count so that a full window of 2^w maps to 256, then saturate to one byte.
   function automatic logic [7:0] norm(input logic [CW-1:0] n, input logic [WLE_W-1:0] w);
      logic [CW+7:0] wide;
      int            wi;
      wi   = int'(w);
      wide = {8'd0, n};
      if (wi >= 8) wide = wide >> (wi - 8);
      else         wide = wide << (8 - wi);
      return (|wide[CW+7:8]) ? 8'hFF : wide[7:0];
   endfunction

   assign wleClamped = (i_windowLengthExp > WLE_W'(MW)) ? WLE_W'(MW) : i_windowLengthExp;
   assign winSize    = CW'(1) << wle_q;
   assign lastT      = winSize - CW'(1);
   assign windowEnd  = i_strobe && ({1'b0, t_q} == lastT);
   assign snapEvent  = i_cg && windowEnd && !i_clear;

   // Incremented counts include the current sample so the snapshot covers the whole window.
   always_comb begin
      cntYInc = cntY + CW'(i_y);
      for (int c = 0; c < N_CH; c++) begin
         cntXInc[c] = cntX[c] + CW'(i_x[c]);
         cntIInc[c] = cntI[c] + CW'(i_x[c] & i_y);
         cntSInc[c] = cntS[c] + CW'(i_x[c] ^ i_y);
      end
      snap[0] = winNum;
      snap[1] = dropCnt;
      snap[2] = norm(cntYInc, wle_q);
      for (int c = 0; c < N_CH; c++) begin
         snap[3 + 3 * c] = norm(cntXInc[c], wle_q);
         snap[4 + 3 * c] = norm(cntIInc[c], wle_q);
         snap[5 + 3 * c] = norm(cntSInc[c], wle_q);
      end
   end

   always_comb begin
      stateNext  = state_q;
      idxNext    = idx_q;
      loadShadow = 1'b0;
      case (state_q)
         IDLE: begin
            if (snapEvent) begin
               loadShadow = 1'b1;
               stateNext  = SEND;
               idxNext    = '0;
            end
         end
         SEND: begin
            if (i_bp_ready) begin
               if (idx_q == IW'(NB - 1)) begin
                  stateNext = IDLE;
                  idxNext   = '0;
               end else begin
                  idxNext = idx_q + 1'b1;
               end
            end
            // A new window may only take the shadow as the last byte leaves.
            if (snapEvent && i_bp_ready && (idx_q == IW'(NB - 1))) begin
               loadShadow = 1'b1;
               stateNext  = SEND;
               idxNext    = '0;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else if (i_cg) begin
         state_q <= stateNext;
         idx_q   <= idxNext;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wle_q   <= '0;
         t_q     <= '0;
         cntY    <= '0;
         winNum  <= '0;
         dropCnt <= '0;
         for (int c = 0; c < N_CH; c++) begin
            cntX[c] <= '0;
            cntI[c] <= '0;
            cntS[c] <= '0;
         end
         for (int i = 0; i < NB; i++) shadow[i] <= '0;
      end else if (i_cg) begin
         if (i_clear) begin
            wle_q   <= wleClamped;
            t_q     <= '0;
            cntY    <= '0;
            winNum  <= '0;
            dropCnt <= '0;
            for (int c = 0; c < N_CH; c++) begin
               cntX[c] <= '0;
               cntI[c] <= '0;
               cntS[c] <= '0;
            end
         end else if (windowEnd) begin
            wle_q  <= wleClamped;
            t_q    <= '0;
            cntY   <= '0;
            winNum <= winNum + 8'd1;
            for (int c = 0; c < N_CH; c++) begin
               cntX[c] <= '0;
               cntI[c] <= '0;
               cntS[c] <= '0;
            end
            if (loadShadow)             dropCnt <= '0;
            else if (dropCnt != 8'hFF)  dropCnt <= dropCnt + 8'd1;
         end else if (i_strobe) begin
            t_q  <= t_q + 1'b1;
            cntY <= cntYInc;
            for (int c = 0; c < N_CH; c++) begin
               cntX[c] <= cntXInc[c];
               cntI[c] <= cntIInc[c];
               cntS[c] <= cntSInc[c];
            end
         end
         if (loadShadow) begin
            for (int i = 0; i < NB; i++) shadow[i] <= snap[i];
         end
      end
   end

   assign o_bp_valid = (state_q == SEND);
   assign o_bp_data  = o_bp_valid ? shadow[idx_q] : 8'd0;
endmodule

// File: tb/tb_multi_correlator.sv
// Directed bench for multi_correlator (N_CH=2) with a window-level reference model and literal packet checks.
module tb_multi_correlator;
   localparam int NCH  = 2;
   localparam int MAXW = 16;
   localparam int WW   = $clog2(MAXW + 1);
   localparam int NB   = 3 + 3 * NCH;

   logic           clk = 1'b0;
   logic           rst_n, cg, strobe, y, clear, ready;
   logic [NCH-1:0] x;
   logic [WW-1:0]  wle;
   logic [7:0]     data;
   logic           valid;

   always #5 clk = ~clk;

   multi_correlator #(.N_CH(NCH), .MAX_WINDOW_LENGTH_EXP(MAXW)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_cg(cg), .i_strobe(strobe), .i_x(x), .i_y(y),
      .i_windowLengthExp(wle), .i_clear(clear),
      .o_bp_data(data), .o_bp_valid(valid), .i_bp_ready(ready)
   );

   int nCmp = 0;
   int nErr = 0;
   logic [7:0] rxq [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCmp++;
      if (act !== exp) begin
         nErr++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: window totals and a packet-in-flight cursor.
   int mT, mW, mY, mWin, mDrop, mPos;
   int mX [NCH];
   int mI [NCH];
   int mS [NCH];
   int mPkt [NB];
   bit mBusy, canLoad;

   function automatic int normRef(int n, int w);
      longint v;
      v = (longint'(n) * 256) / (longint'(1) << w);
      return (v > 255) ? 255 : int'(v);
   endfunction

   function automatic int clampW(int v);
      return (v > MAXW) ? MAXW : v;
   endfunction

   task automatic zeroWindow();
      mT = 0; mY = 0;
      for (int c = 0; c < NCH; c++) begin mX[c] = 0; mI[c] = 0; mS[c] = 0; end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zeroWindow();
         mW = 0; mWin = 0; mDrop = 0; mPos = 0; mBusy = 0;
      end else if (cg) begin
         canLoad = !mBusy || (ready && mPos == NB - 1);
         if (mBusy && ready) begin
            mPos++;
            if (mPos == NB) begin mBusy = 0; mPos = 0; end
         end
         if (clear) begin
            zeroWindow();
            mWin = 0; mDrop = 0; mW = clampW(int'(wle));
         end else if (strobe) begin
            mT++;
            mY += int'(y);
            for (int c = 0; c < NCH; c++) begin
               mX[c] += int'(x[c]);
               mI[c] += int'(x[c] & y);
               mS[c] += int'(x[c] ^ y);
            end
            if (mT == (1 << mW)) begin
               if (canLoad) begin
                  mPkt[0] = mWin; mPkt[1] = mDrop; mPkt[2] = normRef(mY, mW);
                  for (int c = 0; c < NCH; c++) begin
                     mPkt[3 + 3 * c] = normRef(mX[c], mW);
                     mPkt[4 + 3 * c] = normRef(mI[c], mW);
                     mPkt[5 + 3 * c] = normRef(mS[c], mW);
                  end
                  mDrop = 0; mBusy = 1; mPos = 0;
               end else if (mDrop < 255) begin
                  mDrop++;
               end
               mWin = (mWin + 1) % 256;
               zeroWindow();
               mW = clampW(int'(wle));
            end
         end
      end
   end

   // Single compare point, mid-cycle, every cycle.
   always @(negedge clk) begin
      check("valid", {31'd0, valid}, {31'd0, mBusy});
      check("data", {24'd0, data}, mBusy ? mPkt[mPos] : 0);
      if (valid && ready) rxq.push_back(data);
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic sample(input logic [NCH-1:0] xv, input logic yv);
      strobe = 1'b1; x = xv; y = yv;
      tick();
      strobe = 1'b0;
   endtask

   task automatic doClear();
      clear = 1'b1; tick(); clear = 1'b0;
   endtask

   task automatic checkPkt(input string name, input int off, input logic [8*NB-1:0] exp);
      for (int i = 0; i < NB; i++)
         check(name, (off + i < rxq.size()) ? {24'd0, rxq[off + i]} : 32'hDEAD,
               {24'd0, exp[8*(NB-1-i) +: 8]});
   endtask

   initial begin
      rst_n = 1'b0; cg = 1'b1; strobe = 1'b0; x = '0; y = 1'b0;
      wle = '0; clear = 1'b0; ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", {31'd0, valid}, 0);
      check("rst_data", {24'd0, data}, 0);
      rst_n = 1'b1;
      tick();

      // w=3, x0=1, x1=0, y=1
      wle = WW'(3); doClear(); rxq.delete();
      repeat (8) sample(2'b01, 1'b1);
      idle(12);
      checkPkt("pkt_full", 0, 72'h00_00_FF_FF_FF_00_00_00_FF);

      // w=3, x0 toggling
      rxq.delete();
      for (int i = 0; i < 8; i++) sample((i % 2 == 0) ? 2'b01 : 2'b00, 1'b1);
      idle(12);
      checkPkt("pkt_toggle", 0, 72'h01_00_FF_80_80_80_00_00_FF);

      // w=10, half the samples with x0=y=1
      wle = WW'(10); doClear(); rxq.delete();
      for (int i = 0; i < 1024; i++) sample((i < 512) ? 2'b01 : 2'b00, i < 512);
      idle(12);
      checkPkt("pkt_w10", 0, 72'h00_00_80_80_80_00_00_00_80);

      // Stall across three dropped windows
      wle = '0; doClear(); ready = 1'b0; rxq.delete();
      sample(2'b00, 1'b1);
      idle(3);
      check("stall_valid", {31'd0, valid}, 1);
      check("stall_data", {24'd0, data}, 0);
      repeat (3) sample(2'b00, 1'b1);
      idle(2);
      check("stall_hold", {24'd0, data}, 0);
      ready = 1'b1;
      idle(12);
      sample(2'b00, 1'b1);
      idle(12);
      checkPkt("pkt_stalled", 0, 72'h00_00_FF_00_00_FF_00_00_FF);
      checkPkt("pkt_after_drop", NB, 72'h04_03_FF_00_00_FF_00_00_FF);

      // Back-to-back packets, strobe every NB cycles
      doClear(); rxq.delete();
      for (int p = 0; p < 3; p++) begin
         sample(2'b11, 1'b1);
         check("b2b_valid", {31'd0, valid}, 1);
         repeat (NB - 1) begin tick(); check("b2b_valid", {31'd0, valid}, 1); end
      end
      idle(3);
      for (int p = 0; p < 3; p++) begin
         check("b2b_win", (p * NB < rxq.size()) ? {24'd0, rxq[p * NB]} : 32'hDEAD, p);
         check("b2b_drop", (p * NB + 1 < rxq.size()) ? {24'd0, rxq[p * NB + 1]} : 32'hDEAD, 0);
      end
      check("b2b_idle", {31'd0, valid}, 0);

      // Gated strobe is ignored
      cg = 1'b0; sample(2'b01, 1'b1); cg = 1'b1;
      idle(3);
      check("cg_ignored", {31'd0, valid}, 0);

      // Clear coinciding with a window end
      wle = WW'(1); doClear();
      sample(2'b00, 1'b1);
      clear = 1'b1; sample(2'b00, 1'b1); clear = 1'b0;
      idle(2);
      check("clear_no_pkt", {31'd0, valid}, 0);
      sample(2'b00, 1'b1);
      check("clear_t_zero", {31'd0, valid}, 0);
      sample(2'b00, 1'b1);
      check("clear_then_end", {31'd0, valid}, 1);
      idle(12);

      // Async reset mid-packet
      wle = '0; tick();
      sample(2'b01, 1'b0);
      idle(3);
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", {31'd0, valid}, 0);
      check("arst_data", {24'd0, data}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1; rxq.delete();
      tick();
      sample(2'b01, 1'b0);
      idle(12);
      check("arst_win0", (rxq.size() > 0) ? {24'd0, rxq[0]} : 32'hDEAD, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end
endmodule
